ctl_chan_src: RTL and testbench
===============================

# ctl_chan_src

Clocked source for the conditional-sink control channel. Clocked decision logic pushes 1-bit route/discard decisions into a small FIFO. The block replays each decision as one 4-phase bundled-data token on `rctl_o`/`dctl_o`/`actl_o`, and feeds directly into the control input of the conditional sink. It is the boundary where the synchronous decision domain meets the self-timed data path.

## Interface

Parameters:
- `Rpol`, 1'b1 — reset polarity; fixed at active-high for this block.
- `DEPTH`, 4 — decision FIFO depth; power of two, ≥2.
- `SYNC_STAGES`, 2 — flops in the ack synchronizer; ≥2. Only used when the sync feature is compiled in.

Ports:
- `clk`  in  1  — sole clock.
- `rst`  in  1  — synchronous, active-high reset.
- `push_i`  in  1  — decision write strobe, sampled on rising `clk`.
- `dec_i`  in  1  — decision bit; 1 = pass token, 0 = discard token.
- `full_o`  out  1  — FIFO holds `DEPTH` entries.
- `count_o`  out  $clog2(DEPTH+1)  — current FIFO occupancy.
- `ovf_o`  out  1  — sticky flag; a push was dropped.
- `rctl_o`  out  1  — control-channel request.
- `dctl_o`  out  1  — control-channel data; bundled with `rctl_o`.
- `actl_o`  in  1  — control-channel acknowledge from the sink; asynchronous to `clk`.

## Operation

- FIFO: circular buffer, `DEPTH` × 1 bit; pointers wrap modulo `DEPTH`.
- Push: accepted when `push_i`=1 and either `full_o`=0 or a pop occurs in the same cycle.
- Dropped push: `push_i`=1 while full with no pop. The entry is dropped and `ovf_o` is set; it clears only on `rst`.
- Occupancy: `count_o` changes by push − pop each cycle, so a simultaneous push and pop leaves it unchanged.
- Ack handling: `ack_s` is the (optionally synchronized) `actl_o`.
- FSM states and transitions:
  - IDLE — `rctl_o`=0. Goes to SETUP when count>0 and `ack_s`=0.
  - SETUP — `dctl_o` is loaded from the FIFO head; `rctl_o` stays 0. Goes to REQ unconditionally after one cycle.
  - REQ — `rctl_o`=1. When `ack_s`=1: pop the head and go to RTZ.
  - RTZ — `rctl_o`=0. When `ack_s`=0: go to IDLE.
- `dctl_o` holds its value from SETUP through the end of RTZ, and stays stable otherwise.
- All outputs are registered.
- Reset values: `rctl_o`=0, `dctl_o`=0, `full_o`=0, `count_o`=0, `ovf_o`=0, FSM in IDLE, FIFO empty.
- Reset mid-handshake: `rctl_o` drops on the reset edge and the FIFO is flushed. A new token starts only after `ack_s` is seen low in IDLE. The sink therefore always completes its return-to-zero phase.
- The head entry is never popped before its ack, so a token is never lost or duplicated.

## Timing

Push at edge k into an empty FIFO, block in IDLE, `ack_s` low:
- edge k — `count_o`=1.
- edge k+1 — SETUP; `dctl_o` valid.
- edge k+2 — REQ; `rctl_o`=1.

Data setup: `dctl_o` is stable for at least one full clock before `rctl_o` rises.

Ack path:
- Ack rise → pop: `actl_o` rising is seen on `ack_s` after `SYNC_STAGES` edges. Pop, `rctl_o`=0, and count decrement all happen on the next edge.
- Ack fall → new token: `actl_o` falling reaches IDLE after `SYNC_STAGES`+1 edges. The next token's SETUP follows one edge later.

Throughput: with back-to-back tokens and an instant sink, one token per 2·`SYNC_STAGES`+4 cycles.

## Configuration

Macro `CTL_CHAN_SRC_SYNC_EN`:
- Defined: `actl_o` passes through `SYNC_STAGES` flops before the FSM.
- Undefined: `ack_s` = `actl_o` directly, for a sink clocked from the same `clk`. All latencies above then use `SYNC_STAGES`=0.

## Structure

- Shared package `ctl_chan_pkg`:
  - FSM state enum {IDLE, SETUP, REQ, RTZ};
  - occupancy width function `$clog2(DEPTH+1)`.
- One sub-module, `sync_ff`: a `SYNC_STAGES`-deep single-bit synchronizer with synchronous reset to 0. It is instantiated only under `CTL_CHAN_SRC_SYNC_EN`.

## Test plan

1. Single token: reset, then push `dec_i`=1.
   - Required: `dctl_o`=1 at k+1, `rctl_o`=1 at k+2.
   - Ack high for 5 cycles then low: `count_o` returns to 0; exactly one 4-phase cycle.
2. Order and stall: push 1,0,1,1 with the ack held low.
   - Required: `full_o`=1 and `count_o`=4.
   - A 5th push: `ovf_o`=1, `count_o` stays 4.
   - Tokens then emerge with `dctl_o` = 1,0,1,1 in order.
3. Simultaneous push and pop on a full FIFO: push accepted, `count_o` stays 4, `ovf_o` stays 0.
4. Reset mid-handshake: assert `rst` during REQ with the ack high.
   - Required: `rctl_o`=0 the next cycle and `count_o`=0.
   - After a push, no new `rctl_o` rise until the ack has been low for `SYNC_STAGES` cycles.
5. Setup check: on every `rctl_o` rise, `dctl_o` has been stable for ≥1 cycle, and it does not change until RTZ exits.
6. With `CTL_CHAN_SRC_SYNC_EN` undefined: ack high for 1 cycle → pop on the next edge; per-token cycle = 4 clocks with an instant sink.

Source files
------------

// File: rtl/ctl_chan_pkg.sv
// Shared types for the conditional-sink control channel: handshake FSM states
// and the occupancy counter width helper.
package ctl_chan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    RTZ   = 2'd3
  } chan_state_t;

  // Occupancy must be able to represent both 0 and DEPTH.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ctl_chan_src_sync_ff.sv
// Single-bit multi-flop synchronizer with synchronous reset to 0; used to bring
// the sink's acknowledge into the clk domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ctl_chan_src.sv
// Clocked source for the conditional-sink control channel: a decision FIFO
// replayed as 4-phase bundled-data tokens. Define CTL_CHAN_SRC_SYNC_EN to pass
// the acknowledge through a SYNC_STAGES-deep synchronizer.
module ctl_chan_src
  import ctl_chan_pkg::*;
#(
  parameter logic Rpol        = 1'b1,
  parameter int   DEPTH       = 4,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     dec_i,
  output logic                     full_o,
  output logic [occ_w(DEPTH)-1:0]  count_o,
  output logic                     ovf_o,
  output logic                     rctl_o,
  output logic                     dctl_o,
  input  logic                     actl_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ctl_chan_src: DEPTH must be a power of two >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ctl_chan_src: SYNC_STAGES must be >= 2");
  end

  logic rst_a;
  logic ack_s;
  logic launch_ok;

  assign rst_a = (rst == Rpol);

`ifdef CTL_CHAN_SRC_SYNC_EN
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  logic [WARM_W-1:0] warm_cnt;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst_a),
    .d   (actl_o),
    .q   (ack_s)
  );

  // The synchronizer is cleared by reset, so its low output means nothing
  // until it has refilled with real samples of the acknowledge.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_W'(SYNC_STAGES)) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  assign launch_ok = (warm_cnt == WARM_W'(SYNC_STAGES));
`else
  assign ack_s     = actl_o;
  assign launch_ok = 1'b1;
`endif

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nx;
  logic             pop;
  logic             push_ok;
  chan_state_t      state;
  chan_state_t      state_nx;

  // The head is only retired once the sink has acknowledged it.
  assign pop     = (state == REQ) && ack_s;
  assign push_ok = push_i && (!full_o || pop);

  always_comb begin
    count_nx = count_o;
    case ({push_ok, pop})
      2'b10:   count_nx = count_o + CNT_W'(1);
      2'b01:   count_nx = count_o - CNT_W'(1);
      default: count_nx = count_o;
    endcase
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (rst_a) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_o <= count_nx;
      full_o  <= (count_nx == CNT_W'(DEPTH));
      if (push_i && !push_ok) begin
        ovf_o <= 1'b1;
      end
    end
  end

  // On a full push+pop the write lands in the slot being retired; its value
  // already sits in dctl_o, so nothing is lost.
  always_ff @(posedge clk) begin
    if (!rst_a && push_ok) begin
      mem[wr_ptr] <= dec_i;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count_o != '0 && !ack_s && launch_ok) state_nx = SETUP;
      SETUP:   state_nx = REQ;
      REQ:     if (ack_s) state_nx = RTZ;
      RTZ:     if (!ack_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake state and registered channel outputs
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state  <= IDLE;
      rctl_o <= 1'b0;
      dctl_o <= 1'b0;
    end else begin
      state  <= state_nx;
      rctl_o <= (state_nx == REQ);
      if (state == IDLE && state_nx == SETUP) begin
        dctl_o <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_ctl_chan_src.sv
// Self-checking bench for ctl_chan_src in its default build (ack used directly).
`timescale 1ns/1ps
module tb_ctl_chan_src;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          push_i;
  logic          dec_i;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          ovf_o;
  logic          rctl_o;
  logic          dctl_o;
  logic          actl_o;

  logic auto_sink;
  logic man_ack;

  int nvec = 0;
  int nerr = 0;
  bit exp_q[$];
  int gap_q[$];
  int cyc = 0;
  int last_rise = -1;
  int n_rise = 0;
  logic prev_rctl;
  logic prev_dctl;
  logic rst_seen;

  typedef struct {
    bit push;
    bit dec;
    bit ack;
    bit acc;
    int cnt;
    bit full;
    bit ovf;
    bit rctl;
  } vec_t;

  vec_t tbl[10];

  assign actl_o = auto_sink ? rctl_o : man_ack;

  always #5 clk = ~clk;

  ctl_chan_src #(
    .Rpol        (1'b1),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_i),
    .dec_i   (dec_i),
    .full_o  (full_o),
    .count_o (count_o),
    .ovf_o   (ovf_o),
    .rctl_o  (rctl_o),
    .dctl_o  (dctl_o),
    .actl_o  (actl_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    push_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input bit d);
    push_i = 1'b1;
    dec_i  = d;
    exp_q.push_back(d);
    tick();
    push_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    auto_sink = 1'b1;
    push_i    = 1'b0;
    while ((count_o != '0 || rctl_o || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("drain_in_time", n < 200, 1);
    auto_sink = 1'b0;
    man_ack   = 1'b0;
  endtask

  // Monitor: token order, data setup before request, data hold during request
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  always @(negedge clk) begin
    if (rctl_o === 1'b1 && prev_rctl === 1'b0) begin
      n_rise++;
      if (last_rise >= 0) gap_q.push_back(cyc - last_rise);
      last_rise = cyc;
      chk("setup_stable", dctl_o, prev_dctl);
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_token: got dctl %0d with no token pending", dctl_o);
      end else begin
        chk("token_order", dctl_o, exp_q.pop_front());
      end
    end else if (prev_rctl === 1'b1 && rst_seen !== 1'b1) begin
      chk("dctl_hold", dctl_o, prev_dctl);
    end
    prev_rctl = rctl_o;
    prev_dctl = dctl_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst       = 1'b1;
    push_i    = 1'b0;
    dec_i     = 1'b0;
    auto_sink = 1'b0;
    man_ack   = 1'b0;

    tbl[0] = '{1, 1, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 2, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 1, 3, 0, 0, 1};
    tbl[3] = '{1, 1, 0, 1, 4, 1, 0, 1};
    tbl[4] = '{1, 0, 0, 0, 4, 1, 1, 1};
    tbl[5] = '{0, 0, 1, 0, 3, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 3, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 3, 0, 1, 0};
    tbl[8] = '{0, 0, 0, 0, 3, 0, 1, 1};
    tbl[9] = '{0, 0, 1, 0, 2, 0, 1, 0};

    // Reset state
    do_reset();
    chk("rst_count", count_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_rctl", rctl_o, 0);
    chk("rst_dctl", dctl_o, 0);

    // Single token: SETUP at k+1, REQ at k+2, one full 4-phase cycle
    r0 = n_rise;
    push(1'b1);
    chk("t1_count_k", count_o, 1);
    chk("t1_rctl_k", rctl_o, 0);
    tick();
    chk("t1_dctl_k1", dctl_o, 1);
    chk("t1_rctl_k1", rctl_o, 0);
    tick();
    chk("t1_rctl_k2", rctl_o, 1);
    man_ack = 1'b1;
    tick();
    chk("t1_pop_count", count_o, 0);
    chk("t1_pop_rctl", rctl_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_rtz_rctl", rctl_o, 0);
    end
    man_ack = 1'b0;
    tick();
    tick();
    chk("t1_end_count", count_o, 0);
    chk("t1_end_rctl", rctl_o, 0);
    chk("t1_one_token", n_rise - r0, 1);

    // Order, stall, overflow: table-driven
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push_i  = tbl[i].push;
      dec_i   = tbl[i].dec;
      man_ack = tbl[i].ack;
      if (tbl[i].acc) exp_q.push_back(tbl[i].dec);
      tick();
      chk($sformatf("t2_count[%0d]", i), count_o, tbl[i].cnt);
      chk($sformatf("t2_full[%0d]", i), full_o, tbl[i].full);
      chk($sformatf("t2_ovf[%0d]", i), ovf_o, tbl[i].ovf);
      chk($sformatf("t2_rctl[%0d]", i), rctl_o, tbl[i].rctl);
    end
    push_i = 1'b0;
    drain();
    chk("t2_ovf_sticky", ovf_o, 1);

    // Simultaneous push and pop on a full FIFO
    do_reset();
    push(1'b0);
    push(1'b1);
    push(1'b1);
    push(1'b0);
    chk("t3_full", full_o, 1);
    chk("t3_count", count_o, 4);
    chk("t3_rctl", rctl_o, 1);
    man_ack = 1'b1;
    push(1'b1);
    chk("t3_pp_count", count_o, 4);
    chk("t3_pp_full", full_o, 1);
    chk("t3_pp_ovf", ovf_o, 0);
    chk("t3_pp_rctl", rctl_o, 0);
    man_ack = 1'b0;
    drain();
    chk("t3_ovf_end", ovf_o, 0);

    // Reset mid-handshake with the ack high
    do_reset();
    push(1'b1);
    push(1'b0);
    tick();
    chk("t4_req", rctl_o, 1);
    man_ack = 1'b1;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t4_rctl_drop", rctl_o, 0);
    chk("t4_flush", count_o, 0);
    chk("t4_full", full_o, 0);
    push(1'b1);
    chk("t4_count", count_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_wait_ack_low", rctl_o, 0);
    end
    man_ack = 1'b0;
    tick();
    chk("t4_setup_rctl", rctl_o, 0);
    tick();
    chk("t4_req_rctl", rctl_o, 1);
    chk("t4_req_dctl", dctl_o, 1);
    man_ack = 1'b1;
    tick();
    chk("t4_pop_count", count_o, 0);
    man_ack = 1'b0;
    tick();
    tick();

    // Instant sink: pop on the edge after ack rises, 4 clocks per token
    do_reset();
    gap_q.delete();
    last_rise = -1;
    auto_sink = 1'b1;
    push_i = 1'b1;
    dec_i = 1'b1; exp_q.push_back(1'b1); tick();
    dec_i = 1'b0; exp_q.push_back(1'b0); tick();
    dec_i = 1'b1; exp_q.push_back(1'b1); tick();
    push_i = 1'b0;
    chk("t6_req_count", count_o, 3);
    tick();
    chk("t6_pop_count", count_o, 2);
    chk("t6_pop_rctl", rctl_o, 0);
    drain();
    chk("t6_gap_n", gap_q.size(), 2);
    while (gap_q.size() != 0) chk("t6_gap", gap_q.pop_front(), 4);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
